// File: rtl/log_sqrt.sv
// Sequential log-domain converter: out = round(2*log2(in/256)) via leading-one
// normalisation (NORM), threshold rounding (ROUND) and a held result (DONE).
module log_sqrt #(
  parameter int T_LO    = 2436,
  parameter int T_HI    = 3445,
  parameter int EXP_OFS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [6:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [11:0] T_LO_C    = 12'(T_LO);
  localparam logic [11:0] T_HI_C    = 12'(T_HI);
  localparam logic [6:0]  EXP_OFS_C = 7'(EXP_OFS);

  state_t      state_q, state_d;
  logic [11:0] shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        accept;
  logic [1:0]  rnd;
  logic [6:0]  result;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= 12'd0;
      cnt_q       <= 4'd0;
      out_data_q  <= 7'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Rounding step and result; cnt_q holds the leading-one index once normalised
  always_comb begin
    if (shift_q >= T_HI_C) begin
      rnd = 2'd2;
    end else if (shift_q >= T_LO_C) begin
      rnd = 2'd1;
    end else begin
      rnd = 2'd0;
    end
    result = {2'b00, cnt_q, 1'b0} + {5'b00000, rnd} - EXP_OFS_C;
  end

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = in_data;
          cnt_d   = 4'd11;
          if (in_data == 12'd0) begin
            state_d    = DONE;
            out_data_d = 7'h40;
          end else begin
            state_d = NORM;
          end
        end else begin
          state_d = IDLE;
        end
      end
      NORM: begin
        if (shift_q[11]) begin
          state_d = ROUND;
        end else begin
          shift_d = {shift_q[10:0], 1'b0};
          cnt_d   = cnt_q - 4'd1;
        end
      end
      ROUND: begin
        out_data_d = result;
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready    = (state_q == IDLE) && !rst;
    accept      = in_valid && in_ready;
    out_valid_d = (state_d == DONE);
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_log_sqrt.sv
// Self-checking bench for log_sqrt: directed cases, backpressure, reset abort,
// round-trip table sweep and a continuous-valid random sweep against a real-math model.
module tb_log_sqrt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] in_data = 12'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int tests = 0;
  int fails = 0;

  log_sqrt dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // round(2*log2(x/256)) in real arithmetic; zero maps to -64
  function automatic int ref_log(input int x);
    real v;
    if (x == 0) return -64;
    v = 2.0 * ($ln(real'(x) / 256.0) / $ln(2.0));
    return int'($floor(v + 0.5));
  endfunction

  function automatic int ref_lat(input int x);
    int e;
    if (x == 0) return 1;
    e = 0;
    while ((x >> (e + 1)) != 0) e++;
    return 14 - e;
  endfunction

  task automatic check(input string tag, input int obs, input int exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [11:0] d, input int stall);
    int cyc;
    int held;
    cyc = 0;
    while (!in_ready && cyc < 40) begin
      tick();
      cyc++;
    end
    check("ready_before", int'(in_ready), 1);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    in_data  = 12'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check($sformatf("latency_%0d", d), cyc, ref_lat(int'(d)));
    check($sformatf("data_%0d", d), int'($signed(out_data)), ref_log(int'(d)));
    check("busy_ready", int'(in_ready), 0);
    if (stall > 0) begin
      held = int'(out_data);
      repeat (stall) begin
        tick();
        check("bp_valid", int'(out_valid), 1);
        check("bp_data", int'(out_data), held);
        check("bp_ready", int'(in_ready), 0);
      end
      out_ready = 1'b1;
    end
    tick();
    check("valid_drop", int'(out_valid), 0);
    check("ready_back", int'(in_ready), 1);
  endtask

  initial begin
    int got;
    int cyc;
    int seen;
    int k;
    int v;
    int exp_q[$];
    logic [11:0] d;

    // reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", int'(in_ready), 1);

    // directed values, including both rounding thresholds
    run_one(12'd256, 0);
    run_one(12'd362, 0);
    run_one(12'd4095, 0);
    run_one(12'd1, 0);
    run_one(12'd2435, 0);
    run_one(12'd2436, 0);
    run_one(12'd3444, 0);
    run_one(12'd3445, 0);
    run_one(12'd0, 0);

    // backpressure for 5 cycles in DONE
    run_one(12'd1000, 5);

    // reset during NORM abandons the operation
    in_valid = 1'b1;
    in_data  = 12'd1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("rst_mid_ready", int'(in_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_ready_back", int'(in_ready), 1);
    seen = 0;
    repeat (16) begin
      if (out_valid) seen++;
      tick();
    end
    check("rst_no_result", seen, 0);
    run_one(12'd512, 0);

    // round-trip through the sqrt(2^k) table values
    for (k = -16; k <= 8; k++) begin
      v = int'($floor(256.0 * (2.0 ** (real'(k) / 2.0)) + 0.5));
      if (v > 4095) v = 4095;
      run_one(12'(v), 0);
    end

    // random sweep with in_valid held high continuously
    in_valid  = 1'b1;
    out_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 150 && cyc < 5000) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) begin
          check("rand_data", int'($signed(out_data)), exp_q.pop_front());
        end else begin
          check("rand_unexpected", 1, 0);
        end
        got++;
      end
      d = 12'($urandom_range(0, 4095) >> $urandom_range(0, 11));
      in_data = d;
      if (in_ready && in_valid) exp_q.push_back(ref_log(int'(d)));
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("rand_count", got, 150);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
